// File: rtl/rs232_receive_fifo.sv
// Purpose: RS-232 8N1 receiver feeding a first-word-fall-through byte FIFO with CTS flow control.
// Latency: byte written on the stop-bit sample edge; valid rises the following cycle.
// Backpressure: consumer ready pops the head; a full FIFO drops good bytes (overrun pulse), cts_n asserts near full.
//
// Ports:
//   clock          - single clock, all logic on rising edge
//   reset          - asynchronous active-high reset
//   rs232_txd      - asynchronous serial input from the host, idle high
//   rs232_cts_n    - registered active-low clear-to-send back to the host
//   data/valid     - FIFO head byte and its occupancy flag (valid = level != 0)
//   ready          - consumer accepts the head byte on a valid&&ready edge
//   level          - FIFO occupancy, 0..DEPTH
//   framing_error  - one-cycle pulse when the stop bit samples low
//   overrun        - one-cycle pulse when a good byte is dropped on a full FIFO
module rs232_receive_fifo #(
    parameter int CLOCK_FREQ   = 133000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rs232_txd,
    output logic                     rs232_cts_n,
    output logic [7:0]               data,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     framing_error,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Sample point n half-bits after the start edge. Done in 64 bits because
    // CLOCK_FREQ*19 overflows a 32-bit int for realistic clock rates.
    function automatic longint t_at(input int n);
        return (longint'(CLOCK_FREQ) * longint'(n)) / (longint'(2) * longint'(BAUD_RATE));
    endfunction

    localparam longint T_STOP_L = t_at(19);
    localparam int     TW       = $clog2(T_STOP_L + 1);

    localparam logic [TW-1:0] T_START = TW'(t_at(1));
    localparam logic [TW-1:0] T_STOP  = TW'(T_STOP_L);
    localparam logic [TW-1:0] T_BIT [0:7] = '{
        TW'(t_at(3)),  TW'(t_at(5)),  TW'(t_at(7)),  TW'(t_at(9)),
        TW'(t_at(11)), TW'(t_at(13)), TW'(t_at(15)), TW'(t_at(17))
    };

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] CTS_THRESH = LW'(DEPTH - AFULL_MARGIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle (high) line level
    // ------------------------------------------------------------------
    logic sync_meta;
    logic rx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= rs232_txd;
            rx        <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          frame_good;
    logic          frame_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // The timer runs continuously from the start edge (timer=1 on entry to
    // START) through the stop sample, so every sample point is an absolute
    // offset and fractional clocks-per-bit never accumulate error.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        frame_good  = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (!rx) begin
                    state_nxt = ST_START;
                    timer_nxt = TW'(1);
                end
            end
            ST_START: begin
                timer_nxt = timer + TW'(1);
                if (timer == T_START) begin
                    if (rx) begin
                        // start bit did not hold to mid-bit: treat as a glitch
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end else begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = '0;
                    end
                end
            end
            ST_DATA: begin
                timer_nxt = timer + TW'(1);
                if (timer == T_BIT[bit_idx]) begin
                    shift_nxt   = {rx, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                timer_nxt = timer + TW'(1);
                if (timer == T_STOP) begin
                    timer_nxt = '0;
                    if (rx) begin
                        frame_good = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // a break keeps the line low; wait for idle before re-arming
                timer_nxt = '0;
                if (rx) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr_en;
    logic          pop;

    assign full  = (level == LEVEL_FULL);
    // Fullness is judged before the edge, so a pop on the same edge as a
    // good frame into a full FIFO does not rescue the byte.
    assign wr_en = frame_good && !full;
    assign valid = (level != '0);
    assign pop   = valid && ready;
    assign data  = valid ? mem[rd_ptr] : 8'd0;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs232_cts_n   <= 1'b1;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rs232_cts_n   <= (level >= CTS_THRESH);
            framing_error <= frame_bad;
            overrun       <= frame_good && full;
        end
    end

endmodule

// File: tb/tb_rs232_receive_fifo.sv
// Purpose: directed self-checking bench for rs232_receive_fifo (16 clocks per bit, DEPTH=4).
// Latency: frames take 160 clocks on the line; byte lands in the FIFO 155 clocks after the start edge.
// Backpressure: bench drives ready directly to exercise pop, hold, overrun and CTS behaviour.
module tb_rs232_receive_fifo;

    logic       clock;
    logic       reset;
    logic       rs232_txd;
    logic       rs232_cts_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [2:0] level;
    logic       framing_error;
    logic       overrun;

    rs232_receive_fifo #(
        .CLOCK_FREQ  (1600),
        .BAUD_RATE   (100),
        .DEPTH       (4),
        .AFULL_MARGIN(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rs232_txd    (rs232_txd),
        .rs232_cts_n  (rs232_cts_n),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .level        (level),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Monitor: samples on the falling edge, away from the active edge.
    int         n_valid_cyc = 0;
    int         n_ferr      = 0;
    int         n_ovr       = 0;
    int         lvl_max     = 0;
    logic [7:0] popped [$];

    always @(negedge clock) begin
        if (!reset) begin
            if (valid) n_valid_cyc++;
            if (valid && ready) popped.push_back(data);
            if (framing_error) n_ferr++;
            if (overrun) n_ovr++;
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // 8N1 frame, 16 clocks per bit; optional extra low time after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int post_low);
        rs232_txd = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rs232_txd = b[i];
            repeat (16) tick();
        end
        rs232_txd = stop_bit;
        repeat (16) tick();
        if (post_low > 0) begin
            rs232_txd = 1'b0;
            repeat (post_low) tick();
        end
        rs232_txd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       exp_pop;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, v0, f0, o0, base;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hC3, 1'b0, 1'b0, 1'b1};

        reset     = 1'b1;
        rs232_txd = 1'b1;
        ready     = 1'b1;
        repeat (3) tick();
        chk("rst_cts_n", rs232_cts_n, 1);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_level", level, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        tick();
        chk("cts_after_release", rs232_cts_n, 0);
        repeat (5) tick();

        // Table-driven single frames with ready=1
        for (int i = 0; i < 4; i++) begin
            p0 = popped.size(); v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
            send_frame(vecs[i].dat, vecs[i].stop, 0);
            repeat (20) tick();
            chk($sformatf("row%0d_pops", i), popped.size() - p0, vecs[i].exp_pop);
            if (vecs[i].exp_pop && popped.size() > p0)
                chk($sformatf("row%0d_byte", i), popped[popped.size()-1], vecs[i].dat);
            chk($sformatf("row%0d_valid_cycles", i), n_valid_cyc - v0, vecs[i].exp_pop);
            chk($sformatf("row%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            chk($sformatf("row%0d_ovr", i), n_ovr - o0, 0);
            chk($sformatf("row%0d_level", i), level, 0);
            chk($sformatf("row%0d_cts", i), rs232_cts_n, 0);
        end

        // Glitch: 4 clocks low, then a good frame
        p0 = popped.size(); f0 = n_ferr; o0 = n_ovr;
        rs232_txd = 1'b0;
        repeat (4) tick();
        rs232_txd = 1'b1;
        repeat (30) tick();
        chk("glitch_pops", popped.size() - p0, 0);
        chk("glitch_level", level, 0);
        chk("glitch_ferr", n_ferr - f0, 0);
        send_frame(8'h5A, 1'b1, 0);
        repeat (20) tick();
        chk("after_glitch_pops", popped.size() - p0, 1);
        if (popped.size() > p0) chk("after_glitch_byte", popped[popped.size()-1], 8'h5A);
        chk("after_glitch_flags", (n_ferr - f0) + (n_ovr - o0), 0);

        // Break: bad stop bit, line held low 100 clocks
        p0 = popped.size(); v0 = n_valid_cyc; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 100);
        chk("break_ferr_during", n_ferr - f0, 1);
        chk("break_level_during", level, 0);
        repeat (200) tick();
        chk("break_ferr_total", n_ferr - f0, 1);
        chk("break_no_write", (popped.size() - p0) + (n_valid_cyc - v0), 0);
        chk("break_level_after", level, 0);

        // Fill with ready=0: CTS and overrun
        ready = 1'b0;
        o0 = n_ovr;
        for (int f = 1; f <= 5; f++) begin
            send_frame(8'(f), 1'b1, 0);
            repeat (4) tick();
            chk($sformatf("fill%0d_level", f), level, (f > 4) ? 4 : f);
            chk($sformatf("fill%0d_cts", f), rs232_cts_n, (f >= 2) ? 1 : 0);
            chk($sformatf("fill%0d_ovr", f), n_ovr - o0, (f == 5) ? 1 : 0);
        end
        chk("fill_hold_data", data, 8'h01);
        chk("fill_hold_valid", valid, 1);
        base = popped.size();
        for (int i = 0; i < 4; i++) begin
            ready = 1'b1;
            tick();
            ready = 1'b0;
            tick();
            chk($sformatf("drain%0d_level", i), level, 3 - i);
            chk($sformatf("drain%0d_cts", i), rs232_cts_n, ((3 - i) >= 2) ? 1 : 0);
        end
        chk("drain_count", popped.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (popped.size() > base + i)
                chk($sformatf("drain_byte%0d", i), popped[base+i], 8'(i + 1));

        // Reset during bit 3 of a frame (line high in that bit)
        send_frame(8'h77, 1'b1, 0);
        repeat (4) tick();
        chk("pre_reset_level", level, 1);
        rs232_txd = 1'b0;
        repeat (16 + 48) tick();
        rs232_txd = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        chk("midrst_cts_n", rs232_cts_n, 1);
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_level", level, 0);
        chk("midrst_ferr", framing_error, 0);
        chk("midrst_ovr", overrun, 0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        p0 = popped.size(); f0 = n_ferr; o0 = n_ovr;
        ready = 1'b1;
        send_frame(8'h81, 1'b1, 0);
        repeat (20) tick();
        chk("post_reset_pops", popped.size() - p0, 1);
        if (popped.size() > p0) chk("post_reset_byte", popped[popped.size()-1], 8'h81);
        chk("post_reset_flags", (n_ferr - f0) + (n_ovr - o0), 0);
        chk("post_reset_level", level, 0);

        // Simultaneous write and pop at level 1
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        repeat (4) tick();
        chk("simul_pre_level", level, 1);
        lvl_max = 0;
        p0 = popped.size();
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                repeat (154) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        join
        repeat (4) tick();
        chk("simul_level", level, 1);
        chk("simul_level_max", lvl_max, 1);
        chk("simul_data", data, 8'h22);
        chk("simul_pops", popped.size() - p0, 1);
        if (popped.size() > p0) chk("simul_first_byte", popped[p0], 8'h11);
        ready = 1'b1;
        repeat (3) tick();
        chk("simul_drain_level", level, 0);
        if (popped.size() > p0 + 1) chk("simul_second_byte", popped[p0+1], 8'h22);
        else chk("simul_second_count", popped.size() - p0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
